// File: rtl/bus_arbiter.sv
// bus_arbiter: merges the core's instruction bus (ibus) and data bus (dbus)
// onto a single memory-side bus (cbus). It has one outstanding transaction at
// a time. dbus has priority. After MAX_D_RUN back-to-back dbus grants while
// ibus is waiting, ibus is granted next so that it cannot starve.
//
// Ports
//   clk, reset        : clock; synchronous active-high reset
//   ireq_* / iresp_*  : ibus request in, and accept/data responses out
//   dreq_* / dresp_*  : dbus request in, and accept/completion responses out
//   creq_*            : memory-side request out; creq_ready is the accept
//   cresp_*           : memory-side response in
module bus_arbiter #(
  parameter int MAX_D_RUN = 4,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_addr_ok,
  output logic              iresp_data_ok,
  output logic [31:0]       iresp_data,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [7:0]        dreq_strobe,
  input  logic [DATA_W-1:0] dreq_data,
  output logic              dresp_addr_ok,
  output logic              dresp_data_ok,
  output logic [DATA_W-1:0] dresp_data,
  output logic              creq_valid,
  output logic              creq_is_write,
  output logic [ADDR_W-1:0] creq_addr,
  output logic [2:0]        creq_size,
  output logic [7:0]        creq_strobe,
  output logic [DATA_W-1:0] creq_data,
  input  logic              creq_ready,
  input  logic              cresp_valid,
  input  logic [DATA_W-1:0] cresp_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam int              RUN_W   = $clog2(MAX_D_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_D_RUN);

  state_t            state_q, state_d;
  logic              own_d_q, own_d_d;   // 1: dbus owns the transaction, 0: ibus
  logic [RUN_W-1:0]  d_run_q, d_run_d;   // consecutive D grants while I waited
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [7:0]        strobe_q, strobe_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      own_d_q  <= 1'b0;
      d_run_q  <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      own_d_q  <= own_d_d;
      d_run_q  <= d_run_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
    end
  end

  // Next-state logic. Requests are sampled only in IDLE, so the latched
  // request fields cannot change while the request is in flight.
  always_comb begin
    state_d  = state_q;
    own_d_d  = own_d_q;
    d_run_d  = d_run_q;
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    wr_d     = wr_q;
    case (state_q)
      S_IDLE: begin
        if (dreq_valid && !(ireq_valid && d_run_q == RUN_MAX)) begin
          state_d  = S_ISSUE;
          own_d_d  = 1'b1;
          addr_d   = dreq_addr;
          size_d   = dreq_size;
          strobe_d = dreq_strobe;
          data_d   = dreq_data;
          wr_d     = |dreq_strobe;
          // Count only the D grants that made a waiting I request wait longer.
          if (!ireq_valid)             d_run_d = '0;
          else if (d_run_q != RUN_MAX) d_run_d = d_run_q + 1'b1;
        end else if (ireq_valid) begin
          state_d  = S_ISSUE;
          own_d_d  = 1'b0;
          addr_d   = ireq_addr;
          size_d   = 3'd3;
          strobe_d = '0;
          data_d   = '0;
          wr_d     = 1'b0;
          d_run_d  = '0;
        end
      end
      S_ISSUE: if (creq_ready)  state_d = S_WAIT;
      S_WAIT:  if (cresp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    creq_valid    = (state_q == S_ISSUE);
    creq_is_write = wr_q;
    creq_addr     = addr_q;
    creq_size     = size_q;
    creq_strobe   = strobe_q;
    creq_data     = data_q;

    iresp_addr_ok = (state_q == S_ISSUE) && creq_ready && !own_d_q;
    dresp_addr_ok = (state_q == S_ISSUE) && creq_ready &&  own_d_q;
    iresp_data_ok = (state_q == S_WAIT) && cresp_valid && !own_d_q;
    dresp_data_ok = (state_q == S_WAIT) && cresp_valid &&  own_d_q;

    // Response data is zero in every cycle that has no data_ok pulse.
    // An ibus fetch returns the 32-bit half selected by address bit 2.
    iresp_data = '0;
    dresp_data = '0;
    if (iresp_data_ok) iresp_data = addr_q[2] ? cresp_data[63:32] : cresp_data[31:0];
    if (dresp_data_ok) dresp_data = cresp_data;
  end

endmodule
